// File: rtl/ysyx_22040365_idu_if.sv
// -----------------------------------------------------------------------------
// ysyx_22040365_idu_if
// Bundle of every handshake/bus signal around the NPC decode stage.
//
// Signals (direction as seen from the decode stage):
//    in_valid  / in_ready / in_inst / in_pc       IFU -> IDU request channel
//    flush                                         kill held and incoming inst
//    out_valid / out_ready                         IDU -> EXU handshake
//    out_pc, out_inst, out_rs1/rs2/rd,
//    out_ren_rs1/rs2, out_wen_rd, out_imm,
//    out_fmt, out_fun3, out_illegal                registered decoded bundle
//    stall_cnt                                     saturating backpressure count
//
// Modports:
//    slave  : the decode stage itself
//    master : the environment (IFU + EXU side) that drives the stage
// -----------------------------------------------------------------------------
interface ysyx_22040365_idu_if #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_inst;
   logic [XLEN-1:0]   in_pc;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_pc;
   logic [31:0]       out_inst;
   logic [4:0]        out_rs1;
   logic [4:0]        out_rs2;
   logic [4:0]        out_rd;
   logic              out_ren_rs1;
   logic              out_ren_rs2;
   logic              out_wen_rd;
   logic [XLEN-1:0]   out_imm;
   logic [2:0]        out_fmt;
   logic [2:0]        out_fun3;
   logic              out_illegal;
   logic [CNT_W-1:0]  stall_cnt;

   modport slave (
      input  in_valid, in_inst, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, out_inst, out_rs1, out_rs2, out_rd,
             out_ren_rs1, out_ren_rs2, out_wen_rd, out_imm, out_fmt,
             out_fun3, out_illegal, stall_cnt
   );

   modport master (
      output in_valid, in_inst, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_inst, out_rs1, out_rs2, out_rd,
             out_ren_rs1, out_ren_rs2, out_wen_rd, out_imm, out_fmt,
             out_fun3, out_illegal, stall_cnt
   );
endinterface

// File: rtl/ysyx_22040365_idu.sv
// -----------------------------------------------------------------------------
// ysyx_22040365_idu
// Registered RV32I/RV64I base-integer decode stage sitting between the IFU
// and the EXU. Decodes all base formats (R/I/S/B/U/J), produces register-file
// enables, a sign-extended immediate and an illegal-encoding flag, and holds
// the result in a single pipeline register with valid/ready on both sides.
//
// Parameters:
//    XLEN   datapath width (32 or 64); 64 also enables OP-IMM-32 / OP-32
//    CNT_W  width of the saturating stall counter
//    Both must match the parameters of the connected interface instance.
//
// Ports:
//    clk    clock
//    rst    synchronous active-high reset
//    bus    ysyx_22040365_idu_if.slave (request, flush, decoded bundle,
//           stall counter)
// -----------------------------------------------------------------------------
module ysyx_22040365_idu #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   ysyx_22040365_idu_if.slave     bus
);

   // ---------------------------------------------------------------------
   // Base-ISA major opcodes
   // ---------------------------------------------------------------------
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   // Word-variant opcodes only exist on a 64-bit datapath.
   localparam bit HAS_WORD_OPS = (XLEN == 64);

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd7
   } fmt_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            ren_rs1;
      logic            ren_rs2;
      logic            wen_rd;
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic [2:0]      fun3;
      logic            illegal;
   } bundle_t;

   // Every immediate fits in 32 bits with inst[31] as its sign bit, so build
   // it at 32 bits and widen in one place. This also covers U-type on RV64.
   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   // ---------------------------------------------------------------------
   // Combinational decode of the incoming instruction
   // ---------------------------------------------------------------------
   logic [31:0] inst;
   logic [6:0]  opcode;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;

   assign inst   = bus.in_inst;
   assign opcode = inst[6:0];

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   fmt_e        dec_fmt;
   logic [31:0] dec_imm32;
   logic        dec_ren_rs1;
   logic        dec_ren_rs2;
   logic        dec_wen_rd;
   logic        dec_legal;

   // Only a legal encoding ever sets an enable, a format or an immediate, so
   // illegal instructions fall out of the defaults: enables 0, fmt 7, imm 0.
   always_comb begin
      dec_fmt     = FMT_NONE;
      dec_imm32   = '0;
      dec_ren_rs1 = 1'b0;
      dec_ren_rs2 = 1'b0;
      dec_wen_rd  = 1'b0;
      dec_legal   = 1'b0;

      if (inst[1:0] == 2'b11) begin
         case (opcode)
            OPC_OP: begin
               dec_fmt     = FMT_R;
               dec_ren_rs1 = 1'b1;
               dec_ren_rs2 = 1'b1;
               dec_wen_rd  = 1'b1;
               dec_legal   = 1'b1;
            end
            OPC_OP_32: begin
               if (HAS_WORD_OPS) begin
                  dec_fmt     = FMT_R;
                  dec_ren_rs1 = 1'b1;
                  dec_ren_rs2 = 1'b1;
                  dec_wen_rd  = 1'b1;
                  dec_legal   = 1'b1;
               end
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
               dec_fmt     = FMT_I;
               dec_imm32   = imm_i;
               dec_ren_rs1 = 1'b1;
               dec_wen_rd  = 1'b1;
               dec_legal   = 1'b1;
            end
            OPC_OP_IMM_32: begin
               if (HAS_WORD_OPS) begin
                  dec_fmt     = FMT_I;
                  dec_imm32   = imm_i;
                  dec_ren_rs1 = 1'b1;
                  dec_wen_rd  = 1'b1;
                  dec_legal   = 1'b1;
               end
            end
            OPC_STORE: begin
               dec_fmt     = FMT_S;
               dec_imm32   = imm_s;
               dec_ren_rs1 = 1'b1;
               dec_ren_rs2 = 1'b1;
               dec_legal   = 1'b1;
            end
            OPC_BRANCH: begin
               dec_fmt     = FMT_B;
               dec_imm32   = imm_b;
               dec_ren_rs1 = 1'b1;
               dec_ren_rs2 = 1'b1;
               dec_legal   = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
               dec_fmt    = FMT_U;
               dec_imm32  = imm_u;
               dec_wen_rd = 1'b1;
               dec_legal  = 1'b1;
            end
            OPC_JAL: begin
               dec_fmt    = FMT_J;
               dec_imm32  = imm_j;
               dec_wen_rd = 1'b1;
               dec_legal  = 1'b1;
            end
            default: begin
               dec_legal = 1'b0;
            end
         endcase
      end
   end

   // Assemble the bundle that gets captured on an accept. Register fields
   // pass through untouched even when the format does not use them.
   bundle_t dec_bundle;

   always_comb begin
      dec_bundle         = '0;
      dec_bundle.pc      = bus.in_pc;
      dec_bundle.inst    = inst;
      dec_bundle.rs1     = inst[19:15];
      dec_bundle.rs2     = inst[24:20];
      dec_bundle.rd      = inst[11:7];
      dec_bundle.fun3    = inst[14:12];
      dec_bundle.fmt     = dec_fmt;
      dec_bundle.imm     = sext32(dec_imm32);
      dec_bundle.ren_rs1 = dec_ren_rs1;
      dec_bundle.ren_rs2 = dec_ren_rs2;
      // Writes to x0 are architecturally discarded; drop the enable here so
      // the EXU/WBU never has to special-case it.
      dec_bundle.wen_rd  = dec_wen_rd && (inst[11:7] != 5'd0);
      dec_bundle.illegal = !dec_legal;
   end

   // ---------------------------------------------------------------------
   // Pipeline register and handshake
   // ---------------------------------------------------------------------
   bundle_t          bundle_q;
   bundle_t          bundle_d;
   logic             valid_q;
   logic             valid_d;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] stall_d;
   logic             in_ready;
   logic             accept;
   logic             stalled;

   // The slot is free when empty or when the EXU drains it this same cycle,
   // which gives back-to-back transfers with no bubble.
   assign in_ready = !valid_q || bus.out_ready;
   // Flush wins over accept: a concurrent request is dropped, not captured.
   assign accept   = bus.in_valid && in_ready && !bus.flush;
   assign stalled  = valid_q && !bus.out_ready;

   always_comb begin
      valid_d  = valid_q;
      bundle_d = bundle_q;
      stall_d  = stall_q;

      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d  = 1'b1;
         bundle_d = dec_bundle;
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end

      // Counts independently of flush; saturates instead of wrapping.
      if (stalled && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
         stall_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         bundle_q <= bundle_d;
         stall_q  <= stall_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = valid_q;
   assign bus.out_pc      = bundle_q.pc;
   assign bus.out_inst    = bundle_q.inst;
   assign bus.out_rs1     = bundle_q.rs1;
   assign bus.out_rs2     = bundle_q.rs2;
   assign bus.out_rd      = bundle_q.rd;
   assign bus.out_ren_rs1 = bundle_q.ren_rs1;
   assign bus.out_ren_rs2 = bundle_q.ren_rs2;
   assign bus.out_wen_rd  = bundle_q.wen_rd;
   assign bus.out_imm     = bundle_q.imm;
   assign bus.out_fmt     = bundle_q.fmt;
   assign bus.out_fun3    = bundle_q.fun3;
   assign bus.out_illegal = bundle_q.illegal;
   assign bus.stall_cnt   = stall_q;

   // While the EXU backpressures, the held bundle must not move.
   a_hold_stable: assert property (
      @(posedge clk) disable iff (rst)
      (valid_q && !bus.out_ready && !bus.flush) |=> (valid_q && $stable(bundle_q))
   );

endmodule

// File: tb/tb_ysyx_22040365_idu.sv
module tb_ysyx_22040365_idu;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx_22040365_idu_if #(.XLEN(64), .CNT_W(32)) b64();
   ysyx_22040365_idu_if #(.XLEN(32), .CNT_W(32)) b32();

   ysyx_22040365_idu #(.XLEN(64), .CNT_W(32)) u_idu64 (.clk(clk), .rst(rst), .bus(b64));
   ysyx_22040365_idu #(.XLEN(32), .CNT_W(32)) u_idu32 (.clk(clk), .rst(rst), .bus(b32));

   typedef struct {
      logic [31:0] inst;
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ren1;
      logic        ren2;
      logic        wen;
      logic        ill;
   } vec_t;

   typedef struct {
      vec_t        v;
      logic [63:0] pc;
   } exp_t;

   vec_t tab64[18];
   vec_t tab32[7];
   exp_t q64[$];
   exp_t q32[$];
   exp_t m64_e;
   exp_t m32_e;
   int   total = 0;
   int   bad   = 0;

   function automatic vec_t mk(input logic [31:0] i, input logic [63:0] m, input logic [2:0] f,
                               input logic r1, input logic r2, input logic w, input logic il);
      vec_t v;
      v.inst = i; v.imm = m; v.fmt = f; v.ren1 = r1; v.ren2 = r2; v.wen = w; v.ill = il;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input exp_t e, input logic [63:0] pc,
                            input logic [31:0] inst, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] fmt,
                            input logic [63:0] imm, input logic r1, input logic r2,
                            input logic w, input logic il);
      logic [31:0] ei;
      ei = e.v.inst;
      chk({tag, ".pc"},   pc, e.pc);
      chk({tag, ".inst"}, 64'(inst), 64'(ei));
      chk({tag, ".rs1"},  64'(rs1), 64'(ei[19:15]));
      chk({tag, ".rs2"},  64'(rs2), 64'(ei[24:20]));
      chk({tag, ".rd"},   64'(rd), 64'(ei[11:7]));
      chk({tag, ".fun3"}, 64'(f3), 64'(ei[14:12]));
      chk({tag, ".fmt"},  64'(fmt), 64'(e.v.fmt));
      chk({tag, ".imm"},  imm, e.v.imm);
      chk({tag, ".ren_rs1"}, 64'(r1), 64'(e.v.ren1));
      chk({tag, ".ren_rs2"}, 64'(r2), 64'(e.v.ren2));
      chk({tag, ".wen_rd"},  64'(w), 64'(e.v.wen));
      chk({tag, ".illegal"}, 64'(il), 64'(e.v.ill));
      $display("%s pc=%h inst=%h fmt=%0d imm=%h ill=%0d", tag, pc, inst, fmt, imm, il);
   endtask

   // Scoreboard consumers: pop one expected bundle per EXU-side transfer.
   always @(negedge clk) begin
      if (!rst && b64.out_valid && b64.out_ready) begin
         if (q64.size() == 0) begin
            total++; bad++;
            $display("FAIL x64.unexpected: got inst %h want no transfer", b64.out_inst);
         end else begin
            m64_e = q64.pop_front();
            check_out("x64", m64_e, b64.out_pc, b64.out_inst, b64.out_rs1, b64.out_rs2,
                      b64.out_rd, b64.out_fun3, b64.out_fmt, b64.out_imm, b64.out_ren_rs1,
                      b64.out_ren_rs2, b64.out_wen_rd, b64.out_illegal);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && b32.out_valid && b32.out_ready) begin
         if (q32.size() == 0) begin
            total++; bad++;
            $display("FAIL x32.unexpected: got inst %h want no transfer", b32.out_inst);
         end else begin
            m32_e = q32.pop_front();
            check_out("x32", m32_e, 64'(b32.out_pc), b32.out_inst, b32.out_rs1, b32.out_rs2,
                      b32.out_rd, b32.out_fun3, b32.out_fmt, 64'(b32.out_imm), b32.out_ren_rs1,
                      b32.out_ren_rs2, b32.out_wen_rd, b32.out_illegal);
         end
      end
   end

   // Offer one instruction until accepted; push its expectation on acceptance.
   // Entered and left at posedge+1.
   task automatic send(input bit wide, input vec_t v, input logic [63:0] pc, input bit rnd);
      exp_t e;
      bit   acc;
      e.v = v; e.pc = pc; acc = 1'b0;
      for (int c = 0; c < 200 && !acc; c++) begin
         if (wide) begin
            b64.in_valid = 1'b1; b64.in_inst = v.inst; b64.in_pc = pc;
            b64.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end else begin
            b32.in_valid = 1'b1; b32.in_inst = v.inst; b32.in_pc = pc[31:0];
            b32.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         @(negedge clk);
         if (wide ? b64.in_ready : b32.in_ready) begin
            if (wide) q64.push_back(e); else q32.push_back(e);
            acc = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!acc) begin
         total++; bad++;
         $display("FAIL send.timeout: got no accept want accept of %h", v.inst);
      end
   endtask

   task automatic drain(input bit wide);
      if (wide) begin b64.in_valid = 1'b0; b64.out_ready = 1'b1; end
      else      begin b32.in_valid = 1'b0; b32.out_ready = 1'b1; end
      for (int c = 0; c < 20 && (wide ? q64.size() : q32.size()) != 0; c++) @(posedge clk);
      chk(wide ? "drain64.left" : "drain32.left", 64'(wide ? q64.size() : q32.size()), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk(wide ? "drain64.valid" : "drain32.valid",
          64'(wide ? b64.out_valid : b32.out_valid), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tab64[0]  = mk(32'h00500093, 64'd5,                   3'd1, 1, 0, 1, 0);
      tab64[1]  = mk(32'hfff08113, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1, 0, 1, 0);
      tab64[2]  = mk(32'h00b53423, 64'd8,                   3'd2, 1, 1, 0, 0);
      tab64[3]  = mk(32'h00000000, 64'd0,                   3'd7, 0, 0, 0, 1);
      tab64[4]  = mk(32'h0010009B, 64'd1,                   3'd1, 1, 0, 1, 0);
      tab64[5]  = mk(32'h00000013, 64'd0,                   3'd1, 1, 0, 0, 0);
      tab64[6]  = mk(32'h002081B3, 64'd0,                   3'd0, 1, 1, 1, 0);
      tab64[7]  = mk(32'hFE208EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1, 1, 0, 0);
      tab64[8]  = mk(32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 0, 0, 1, 0);
      tab64[9]  = mk(32'h008000EF, 64'd8,                   3'd5, 0, 0, 1, 0);
      tab64[10] = mk(32'h8003A303, 64'hFFFF_FFFF_FFFF_F800, 3'd1, 1, 0, 1, 0);
      tab64[11] = mk(32'h0000000F, 64'd0,                   3'd7, 0, 0, 0, 1);
      tab64[12] = mk(32'h00500091, 64'd0,                   3'd7, 0, 0, 0, 1);
      tab64[13] = mk(32'h00000073, 64'd0,                   3'd1, 1, 0, 0, 0);
      tab64[14] = mk(32'h003100BB, 64'd0,                   3'd0, 1, 1, 1, 0);
      tab64[15] = mk(32'h12345037, 64'h0000_0000_1234_5000, 3'd4, 0, 0, 0, 0);
      tab64[16] = mk(32'hFFFFF397, 64'hFFFF_FFFF_FFFF_F000, 3'd4, 0, 0, 1, 0);
      tab64[17] = mk(32'hFE532E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1, 1, 0, 0);

      tab32[0] = mk(32'h0010009B, 64'd0,          3'd7, 0, 0, 0, 1);
      tab32[1] = mk(32'h12345037, 64'h1234_5000,  3'd4, 0, 0, 0, 0);
      tab32[2] = mk(32'h800002B7, 64'h8000_0000,  3'd4, 0, 0, 1, 0);
      tab32[3] = mk(32'h00500093, 64'd5,          3'd1, 1, 0, 1, 0);
      tab32[4] = mk(32'hfff08113, 64'hFFFF_FFFF,  3'd1, 1, 0, 1, 0);
      tab32[5] = mk(32'h003100BB, 64'd0,          3'd7, 0, 0, 0, 1);
      tab32[6] = mk(32'hFE208EE3, 64'hFFFF_FFFC,  3'd3, 1, 1, 0, 0);

      rst = 1'b1;
      b64.in_valid = 1'b0; b64.in_inst = '0; b64.in_pc = '0; b64.flush = 1'b0; b64.out_ready = 1'b0;
      b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_pc = '0; b32.flush = 1'b0; b32.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.valid64", 64'(b64.out_valid), 64'd0);
      chk("rst.fmt64",   64'(b64.out_fmt), 64'd0);
      chk("rst.imm64",   b64.out_imm, 64'd0);
      chk("rst.inst64",  64'(b64.out_inst), 64'd0);
      chk("rst.stall64", 64'(b64.stall_cnt), 64'd0);
      chk("rst.ready64", 64'(b64.in_ready), 64'd1);
      chk("rst.valid32", 64'(b32.out_valid), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Back-to-back with the EXU always ready, then with random backpressure.
      for (int i = 0; i < 18; i++) send(1'b1, tab64[i], 64'h8000_0000 + 64'(4 * i), 1'b0);
      drain(1'b1);
      for (int i = 0; i < 18; i++) send(1'b1, tab64[i], 64'h9000_0000 + 64'(4 * i), 1'b1);
      drain(1'b1);
      for (int i = 0; i < 7; i++) send(1'b0, tab32[i], 64'h8000_0000 + 64'(4 * i), 1'b0);
      drain(1'b0);

      // Reset while a bundle is held drops it and clears the counter.
      b64.in_valid = 1'b1; b64.in_inst = tab64[0].inst; b64.in_pc = 64'h1000; b64.out_ready = 1'b0;
      @(posedge clk); #1;
      b64.in_valid = 1'b0;
      @(negedge clk);
      chk("mrst.held", 64'(b64.out_valid), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mrst.valid", 64'(b64.out_valid), 64'd0);
      chk("mrst.stall", 64'(b64.stall_cnt), 64'd0);
      chk("mrst.inst",  64'(b64.out_inst), 64'd0);
      @(posedge clk); #1;

      // Backpressure: A held for 4 cycles while B waits.
      b64.in_valid = 1'b1; b64.in_inst = tab64[2].inst; b64.in_pc = 64'h2000; b64.out_ready = 1'b0;
      @(negedge clk);
      chk("bp.acc_ready", 64'(b64.in_ready), 64'd1);
      m64_e.v = tab64[2]; m64_e.pc = 64'h2000; q64.push_back(m64_e);
      @(posedge clk); #1;
      b64.in_inst = tab64[6].inst; b64.in_pc = 64'h2004;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp.in_ready", 64'(b64.in_ready), 64'd0);
         chk("bp.valid",    64'(b64.out_valid), 64'd1);
         chk("bp.inst",     64'(b64.out_inst), 64'(tab64[2].inst));
         chk("bp.imm",      b64.out_imm, tab64[2].imm);
         @(posedge clk); #1;
      end
      chk("bp.stall4", 64'(b64.stall_cnt), 64'd4);
      b64.out_ready = 1'b1;
      @(negedge clk);
      chk("bp.release_ready", 64'(b64.in_ready), 64'd1);
      m64_e.v = tab64[6]; m64_e.pc = 64'h2004; q64.push_back(m64_e);
      @(posedge clk); #1;
      b64.in_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp.no_dup",   64'(b64.out_valid), 64'd0);
      chk("bp.left",     64'(q64.size()), 64'd0);
      chk("bp.stall_hold", 64'(b64.stall_cnt), 64'd4);
      @(posedge clk); #1;

      // Flush with a held bundle and an incoming request in the same cycle.
      b64.in_valid = 1'b1; b64.in_inst = tab64[9].inst; b64.in_pc = 64'h3000; b64.out_ready = 1'b0;
      @(posedge clk); #1;
      b64.in_inst = tab64[10].inst; b64.in_pc = 64'h3004; b64.flush = 1'b1;
      @(negedge clk);
      chk("fl.held", 64'(b64.out_valid), 64'd1);
      @(posedge clk); #1;
      b64.flush = 1'b0; b64.in_valid = 1'b0;
      @(negedge clk);
      chk("fl.valid", 64'(b64.out_valid), 64'd0);
      @(posedge clk); #1;
      // Flush on an empty stage with a request offered and EXU ready.
      b64.in_valid = 1'b1; b64.in_inst = tab64[16].inst; b64.in_pc = 64'h3008;
      b64.flush = 1'b1; b64.out_ready = 1'b1;
      @(posedge clk); #1;
      b64.flush = 1'b0; b64.in_valid = 1'b0;
      @(negedge clk);
      chk("fl.empty_valid", 64'(b64.out_valid), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("fl.left", 64'(q64.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ysyx_22040365_idu.md
# ysyx_22040365_idu

Registered, handshaked RV32I/RV64I base-integer decode stage for the NPC core, between the fetch unit (IFU) and the execute unit (EXU). It decodes every base-ISA instruction format (R/I/S/B/U/J), not only OP-IMM. It generates register-file read/write enables and sign-extended immediates, and flags illegal encodings. One pipeline register, a valid/ready handshake in each direction, a flush input and a stall-cycle counter make it a full pipeline stage rather than combinational glue.

## Interface
- XLEN, 64, datapath width (32 or 64); 64 also enables OP-IMM-32/OP-32 (opcodes 0011011/0111011)
- CNT_W, 32, stall counter width
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  IFU offers instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  EXU accepts bundle
- out_pc  out  XLEN  registered PC
- out_inst  out  32  registered raw instruction
- out_rs1, out_rs2, out_rd  out  5 each  register indices (inst[19:15], [24:20], [11:7])
- out_ren_rs1, out_ren_rs2, out_wen_rd  out  1 each  register-file enables
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  R=0, I=1, S=2, B=3, U=4, J=5, none=7
- out_fun3  out  3  inst[14:12]
- out_illegal  out  1  unsupported encoding
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating

## Operation
- Combinational decode of in_inst. The result is captured into the output register on an accept (in_valid && in_ready).
- in_ready = !out_valid || out_ready. This gives full throughput and no bubble on back-to-back transfers.
- Formats and enables:
  - OP, OP-32: R; rs1 + rs2 + rd.
  - OP-IMM, OP-IMM-32, LOAD, JALR, SYSTEM: I; rs1 + rd.
  - STORE: S; rs1 + rs2.
  - BRANCH: B; rs1 + rs2.
  - LUI, AUIPC: U; rd.
  - JAL: J; rd.
- Immediates follow the RISC-V spec, sign-extended from inst[31] to XLEN. U-type is {inst[31:12], 12'b0}, sign-extended when XLEN=64. R-type and illegal instructions produce imm=0.
- out_wen_rd is forced to 0 when rd==0.
- out_illegal=1 when any of these holds:
  - inst[1:0]!=2'b11
  - the opcode is outside the supported set
  - OP-IMM-32 or OP-32 is decoded with XLEN=32
- For an illegal instruction: all enables are 0, out_fmt=7, imm=0, and out_valid is still asserted so the EXU can trap.
- Register fields are passed through unmodified even when unused.
- stall_cnt increments each cycle out_valid && !out_ready and holds at all-ones. It is cleared only by rst.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Reset (rst high at a clock edge) takes priority over everything:
  - out_valid=0
  - all registered outputs 0, with out_fmt=0
  - stall_cnt=0
- Reset asserted mid-transfer drops the held bundle.
- Flush has priority over accept. With flush high at an edge, out_valid becomes 0 next cycle and any concurrent in_valid is discarded. in_ready may be 1 during flush, but nothing is captured.
- Hold rule: while out_valid && !out_ready, all out_* signals are stable and in_ready=0.
- Simultaneous out_ready and in_valid with out_valid=1: the old bundle retires and the new one is captured in the same edge.
- stall_cnt counts the flush cycle if the stall condition held in that cycle.

## Test plan
- Reset, then in_inst=0x00500093 (addi x1,x0,5), pc=0x80000000, out_ready=1. Next cycle requires:
  - out_valid=1, fmt=1, rd=1, rs1=0, imm=5
  - ren_rs1=1, wen_rd=1, ren_rs2=0, illegal=0
- 0xfff08113 (addi x2,x1,-1): imm=0xFFFF_FFFF_FFFF_FFFF. Then 0x00b53423 (sd x11,8(x10)):
  - fmt=2, rs1=10, rs2=11, imm=8, wen_rd=0, ren_rs2=1
- Backpressure: out_ready=0 for 4 cycles with a bundle held and in_valid=1:
  - in_ready=0 and outputs unchanged throughout
  - stall_cnt=4
  - on out_ready=1, the next instruction appears one cycle later with no lost or duplicated transfer
- Flush with out_valid=1 and in_valid=1 in the same cycle: out_valid=0 next cycle, and the incoming instruction never appears.
- 0x00000000 gives illegal=1, fmt=7, all enables 0. 0x0010009B (addiw x1,x0,1):
  - XLEN=64: legal, fmt=1, imm=1
  - XLEN=32: illegal=1
- 0x00000013 (addi x0,x0,0): wen_rd=0. 0x12345037 (lui x0) with XLEN=32: imm=0x12345000, wen_rd=0.
